// File: rtl/aes_axi4lite_responder.sv
// AXI4-lite register front end for an AES-192 encryption core: PT/KEY staging, START pulse, DONE flag, CT capture.
// Optional build macro AES_KEY_READBACK_EN makes the KEY words readable; without it KEY reads return 0 with SLVERR.
module aes_axi4lite_responder #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [AW-1:0] awaddr_i,
   input  logic          awvalid_i,
   output logic          awready_o,
   input  logic [DW-1:0] wdata_i,
   input  logic [DW/8-1:0] wstrb_i,
   input  logic          wvalid_i,
   output logic          wready_o,
   output logic [1:0]    bresp_o,
   output logic          bvalid_o,
   input  logic          bready_i,
   input  logic [AW-1:0] araddr_i,
   input  logic          arvalid_i,
   output logic          arready_o,
   output logic [DW-1:0] rdata_o,
   output logic [1:0]    rresp_o,
   output logic          rvalid_o,
   input  logic          rready_i,
   output logic          aes_start_o,
   output logic [191:0]  aes_key_o,
   output logic [127:0]  aes_pt_o,
   input  logic [127:0]  aes_ct_i,
   input  logic          aes_ct_valid_i,
   output logic [1:0]    wr_state,
   output logic [1:0]    rd_state
);

   // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
   // a valid output stays high with stable payload until that edge.
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACCEPT = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACCEPT = 2'd1, R_DATA = 2'd2} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [31:0]  pt_q [4];
   logic [31:0]  key_q [6];
   logic [127:0] ct_q;
   logic         done_q, busy_q, start_q;
   logic [1:0]   bresp_q, rresp_q;
   logic [31:0]  rdata_q;

   logic         w_fire, r_fire;
   logic [3:0]   wr_idx, rd_idx;
   logic         wr_mapped, rd_mapped;
   logic         wr_err, pt_we, key_we, start_set, start_fire;
   logic [1:0]   pt_off, rd_pt_off, rd_ct_off;
   logic [2:0]   key_off;
   logic         rd_err;
   logic [31:0]  rd_data;
   logic         unused_addr_bits;

   assign unused_addr_bits = ^{awaddr_i[1:0], araddr_i[1:0]};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      return res;
   endfunction

   // ---------------- write FSM ----------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) w_state <= W_IDLE;
      else         w_state <= w_next;
   end

   always_comb begin
      w_next    = w_state;
      awready_o = 1'b0;
      wready_o  = 1'b0;
      bvalid_o  = 1'b0;
      case (w_state)
         W_IDLE:   if (awvalid_i && wvalid_i) w_next = W_ACCEPT;
         W_ACCEPT: begin
            awready_o = 1'b1;
            wready_o  = 1'b1;
            w_next    = W_RESP;
         end
         W_RESP: begin
            bvalid_o = 1'b1;
            if (bready_i) w_next = W_IDLE;
         end
         default:  w_next = W_IDLE;
      endcase
   end

   assign w_fire    = (w_state == W_ACCEPT);
   assign wr_idx    = awaddr_i[5:2];
   assign wr_mapped = (awaddr_i[AW-1:6] == '0);
   assign pt_off    = wr_idx[1:0] - 2'd2;
   assign key_off   = wr_idx[2:0] - 3'd6;

   always_comb begin
      wr_err    = 1'b1;
      pt_we     = 1'b0;
      key_we    = 1'b0;
      start_set = 1'b0;
      if (wr_mapped) begin
         if (wr_idx == 4'd0) begin
            wr_err    = busy_q;
            start_set = !busy_q && wstrb_i[0] && wdata_i[0];
         end else if (wr_idx >= 4'd2 && wr_idx <= 4'd5) begin
            wr_err = busy_q;
            pt_we  = !busy_q;
         end else if (wr_idx >= 4'd6 && wr_idx <= 4'd11) begin
            wr_err = busy_q;
            key_we = !busy_q;
         end
      end
   end

   assign start_fire = w_fire && start_set;

   // Register file; a START on the same edge as a core-done pulse overrides DONE/busy.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++) pt_q[i] <= '0;
         for (int i = 0; i < 6; i++) key_q[i] <= '0;
         ct_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else begin
         start_q <= start_fire;
         if (aes_ct_valid_i) begin
            ct_q   <= aes_ct_i;
            done_q <= 1'b1;
            busy_q <= 1'b0;
         end
         if (start_fire) begin
            done_q <= 1'b0;
            busy_q <= 1'b1;
         end
         if (w_fire && pt_we)  pt_q[pt_off]   <= merge_bytes(pt_q[pt_off], wdata_i, wstrb_i);
         if (w_fire && key_we) key_q[key_off] <= merge_bytes(key_q[key_off], wdata_i, wstrb_i);
         if (w_fire)           bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= R_IDLE;
      else         r_state <= r_next;
   end

   always_comb begin
      r_next    = r_state;
      arready_o = 1'b0;
      rvalid_o  = 1'b0;
      case (r_state)
         R_IDLE:   if (arvalid_i) r_next = R_ACCEPT;
         R_ACCEPT: begin
            arready_o = 1'b1;
            r_next    = R_DATA;
         end
         R_DATA: begin
            rvalid_o = 1'b1;
            if (rready_i) r_next = R_IDLE;
         end
         default:  r_next = R_IDLE;
      endcase
   end

   assign r_fire    = (r_state == R_ACCEPT);
   assign rd_idx    = araddr_i[5:2];
   assign rd_mapped = (araddr_i[AW-1:6] == '0);
   assign rd_pt_off = rd_idx[1:0] - 2'd2;
   // CT is stored little-word-first, but its lowest address holds the top word.
   assign rd_ct_off = 2'd3 - rd_idx[1:0];
`ifdef AES_KEY_READBACK_EN
   logic [2:0] rd_key_off;
   assign rd_key_off = rd_idx[2:0] - 3'd6;
`endif

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b1;
      if (rd_mapped) begin
         if (rd_idx == 4'd1) begin
            rd_data = {31'b0, done_q};
            rd_err  = 1'b0;
         end else if (rd_idx >= 4'd2 && rd_idx <= 4'd5) begin
            rd_data = pt_q[rd_pt_off];
            rd_err  = 1'b0;
         end else if (rd_idx >= 4'd6 && rd_idx <= 4'd11) begin
`ifdef AES_KEY_READBACK_EN
            rd_data = key_q[rd_key_off];
            rd_err  = 1'b0;
`else
            rd_data = '0;
            rd_err  = 1'b1;
`endif
         end else if (rd_idx >= 4'd12) begin
            rd_data = ct_q[rd_ct_off*32 +: 32];
            rd_err  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (r_fire) begin
         rdata_q <= rd_data;
         rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   assign bresp_o     = bresp_q;
   assign rdata_o     = rdata_q;
   assign rresp_o     = rresp_q;
   assign aes_start_o = start_q;
   assign aes_pt_o    = {pt_q[3], pt_q[2], pt_q[1], pt_q[0]};
   assign aes_key_o   = {key_q[5], key_q[4], key_q[3], key_q[2], key_q[1], key_q[0]};
   assign wr_state    = w_state;
   assign rd_state    = r_state;

endmodule

// File: tb/tb_aes_axi4lite_responder.sv
// Directed self-checking bench for aes_axi4lite_responder; expected values are hand-computed constants.
// Honours AES_KEY_READBACK_EN for the KEY readback expectation.
module tb_aes_axi4lite_responder;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   awaddr, wdata, araddr;
   logic [3:0]    wstrb;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp, wr_state, rd_state;
   logic [31:0]   rdata;
   logic          aes_start, aes_ct_valid;
   logic [191:0]  aes_key;
   logic [127:0]  aes_pt, aes_ct;

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;
   logic [127:0] pt_at_start = '0;

   always #5 clk = ~clk;

   aes_axi4lite_responder #(.AW(32), .DW(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
      .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
      .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
      .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
      .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
      .aes_start_o(aes_start), .aes_key_o(aes_key), .aes_pt_o(aes_pt),
      .aes_ct_i(aes_ct), .aes_ct_valid_i(aes_ct_valid),
      .wr_state(wr_state), .rd_state(rd_state)
   );

   // Start-pulse monitor: counts high cycles and snapshots the plaintext presented with it.
   always @(negedge clk) begin
      if (aes_start === 1'b1) begin
         start_cnt++;
         pt_at_start = aes_pt;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit ct_pulse, output logic [1:0] resp);
      int n;
      resp = 2'b11;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (awready !== 1'b1 && n < 20);
      if (awready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL aw_timeout addr=%h: awready=%b required 1", addr, awready);
         awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
         return;
      end
      if (ct_pulse) aes_ct_valid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; aes_ct_valid = 1'b0;
      n = 0;
      while (bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (bvalid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL b_timeout addr=%h: bvalid=%b required 1", addr, bvalid);
      end else begin
         resp = bresp;
      end
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      data = 32'hxxxx_xxxx; resp = 2'b11;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (arready !== 1'b1 && n < 20);
      if (arready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL ar_timeout addr=%h: arready=%b required 1", addr, arready);
         arvalid = 1'b0; rready = 1'b0;
         return;
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (rvalid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL r_timeout addr=%h: rvalid=%b required 1", addr, rvalid);
      end else begin
         data = rdata; resp = rresp;
      end
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic pulse_ct(input logic [127:0] ct);
      @(posedge clk); #1;
      aes_ct = ct; aes_ct_valid = 1'b1;
      @(posedge clk); #1;
      aes_ct_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({awready, wready, bvalid, arready, rvalid, aes_start} !== 6'b0) begin
         errors++; $display("FAIL reset_handshakes: got %b required 000000", {awready, wready, bvalid, arready, rvalid, aes_start}); end
      checks++; if ({bresp, rresp} !== 4'b0) begin
         errors++; $display("FAIL reset_resp: got %b required 0000", {bresp, rresp}); end
      checks++; if (rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: got %h required 0", rdata); end
      checks++; if (aes_key !== 192'h0 || aes_pt !== 128'h0) begin
         errors++; $display("FAIL reset_key_pt: key=%h pt=%h required 0", aes_key, aes_pt); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_key_write();
      logic [31:0] words [6] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588,
                                 32'h09cf4f3c, 32'h2b7e1516, 32'h28aed2a6};
      logic [1:0] resp;
      for (int i = 0; i < 6; i++) begin
         axi_write(32'h2C - 32'(4 * i), words[i], 4'hF, 1'b0, resp);
         checks++; if (resp !== 2'b00) begin
            errors++; $display("FAIL key_bresp[%0d]: got %b required 00", i, resp); end
      end
      checks++; if (aes_key !== 192'h2b7e151628aed2a6abf7158809cf4f3c2b7e151628aed2a6) begin
         errors++; $display("FAIL key_value: got %h required 2b7e151628aed2a6abf7158809cf4f3c2b7e151628aed2a6", aes_key); end
   endtask

   task automatic test_pt_start();
      logic [31:0] words [4] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
      logic [1:0]  resp;
      logic [31:0] data;
      int cnt0;
      for (int i = 0; i < 4; i++) begin
         axi_write(32'h14 - 32'(4 * i), words[i], 4'hF, 1'b0, resp);
         checks++; if (resp !== 2'b00) begin
            errors++; $display("FAIL pt_bresp[%0d]: got %b required 00", i, resp); end
      end
      checks++; if (aes_pt !== 128'h3243f6a8885a308d313198a2e0370734) begin
         errors++; $display("FAIL pt_value: got %h required 3243f6a8885a308d313198a2e0370734", aes_pt); end
      cnt0 = start_cnt;
      axi_write(32'h00, 32'h1, 4'hF, 1'b0, resp);
      checks++; if (resp !== 2'b00) begin
         errors++; $display("FAIL start_bresp: got %b required 00", resp); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (start_cnt - cnt0 !== 1) begin
         errors++; $display("FAIL start_pulse_cycles: got %0d required 1", start_cnt - cnt0); end
      checks++; if (pt_at_start !== 128'h3243f6a8885a308d313198a2e0370734) begin
         errors++; $display("FAIL start_pt: got %h required 3243f6a8885a308d313198a2e0370734", pt_at_start); end
      axi_read(32'h04, data, resp);
      checks++; if (data !== 32'h0 || resp !== 2'b00) begin
         errors++; $display("FAIL done_after_start: got %h/%b required 00000000/00", data, resp); end
   endtask

   task automatic test_busy();
      logic [1:0]  resp;
      logic [31:0] data;
      int cnt0;
      axi_write(32'h08, 32'hffffffff, 4'hF, 1'b0, resp);
      checks++; if (resp !== 2'b10) begin
         errors++; $display("FAIL busy_pt_bresp: got %b required 10", resp); end
      checks++; if (aes_pt !== 128'h3243f6a8885a308d313198a2e0370734) begin
         errors++; $display("FAIL busy_pt_unchanged: got %h", aes_pt); end
      cnt0 = start_cnt;
      axi_write(32'h00, 32'h1, 4'hF, 1'b0, resp);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (resp !== 2'b10 || start_cnt !== cnt0) begin
         errors++; $display("FAIL busy_start: resp=%b pulses=%0d required 10 and 0", resp, start_cnt - cnt0); end
      axi_read(32'h40, data, resp);
      checks++; if (data !== 32'h0 || resp !== 2'b10) begin
         errors++; $display("FAIL unmapped_read: got %h/%b required 00000000/10", data, resp); end
   endtask

   task automatic test_done();
      logic [31:0] exp_ct [4] = '{32'h4fcb8db8, 32'h5784a2c1, 32'hbb77db7e, 32'hde3217ac};
      logic [1:0]  resp;
      logic [31:0] data;
      repeat (10) @(posedge clk);
      pulse_ct(128'h4fcb8db85784a2c1bb77db7ede3217ac);
      axi_read(32'h04, data, resp);
      checks++; if (data !== 32'h1 || resp !== 2'b00) begin
         errors++; $display("FAIL done_set: got %h/%b required 00000001/00", data, resp); end
      for (int i = 0; i < 4; i++) begin
         axi_read(32'h30 + 32'(4 * i), data, resp);
         checks++; if (data !== exp_ct[i] || resp !== 2'b00) begin
            errors++; $display("FAIL ct_word[%0d]: got %h/%b required %h/00", i, data, resp, exp_ct[i]); end
      end
   endtask

   task automatic test_strobe_and_errors();
      logic [1:0]  resp;
      logic [31:0] data;
      int cnt0;
      axi_write(32'h08, 32'haabbccdd, 4'b0101, 1'b0, resp);
      checks++; if (resp !== 2'b00 || aes_pt !== 128'h3243f6a8885a308d313198a2e0bb07dd) begin
         errors++; $display("FAIL pt_strobe: got %h/%b required 3243f6a8885a308d313198a2e0bb07dd/00", aes_pt, resp); end
      cnt0 = start_cnt;
      axi_write(32'h00, 32'h1, 4'b1110, 1'b0, resp);
      checks++; if (resp !== 2'b00) begin
         errors++; $display("FAIL start_nostrb_bresp: got %b required 00", resp); end
      axi_write(32'h00, 32'h0, 4'hF, 1'b0, resp);
      checks++; if (resp !== 2'b00) begin
         errors++; $display("FAIL start_zero_bresp: got %b required 00", resp); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (start_cnt !== cnt0) begin
         errors++; $display("FAIL start_no_effect: pulses=%0d required 0", start_cnt - cnt0); end
      axi_read(32'h04, data, resp);
      checks++; if (data !== 32'h1) begin
         errors++; $display("FAIL done_sticky: got %h required 00000001", data); end
      axi_write(32'h04, 32'h0, 4'hF, 1'b0, resp);
      checks++; if (resp !== 2'b10) begin
         errors++; $display("FAIL done_write_bresp: got %b required 10", resp); end
      axi_write(32'h30, 32'h0, 4'hF, 1'b0, resp);
      checks++; if (resp !== 2'b10) begin
         errors++; $display("FAIL ct_write_bresp: got %b required 10", resp); end
      axi_read(32'h30, data, resp);
      checks++; if (data !== 32'h4fcb8db8) begin
         errors++; $display("FAIL ct_after_write: got %h required 4fcb8db8", data); end
   endtask

   task automatic test_start_ct_same_edge();
      logic [1:0]  resp;
      logic [31:0] data;
      int cnt0;
      cnt0 = start_cnt;
      aes_ct = 128'h00112233445566778899aabbccddeeff;
      axi_write(32'h00, 32'h1, 4'h1, 1'b1, resp);
      checks++; if (resp !== 2'b00) begin
         errors++; $display("FAIL same_edge_bresp: got %b required 00", resp); end
      axi_read(32'h04, data, resp);
      checks++; if (data !== 32'h0 || start_cnt - cnt0 !== 1) begin
         errors++; $display("FAIL same_edge_done: done=%h pulses=%0d required 0 and 1", data, start_cnt - cnt0); end
      axi_read(32'h30, data, resp);
      checks++; if (data !== 32'h00112233) begin
         errors++; $display("FAIL same_edge_ct: got %h required 00112233", data); end
      axi_write(32'h0C, 32'h0, 4'hF, 1'b0, resp);
      checks++; if (resp !== 2'b10) begin
         errors++; $display("FAIL same_edge_busy: got %b required 10", resp); end
      pulse_ct(128'h00112233445566778899aabbccddeeff);
      axi_read(32'h04, data, resp);
      checks++; if (data !== 32'h1) begin
         errors++; $display("FAIL done_after_second_ct: got %h required 00000001", data); end
   endtask

   task automatic test_back_to_back_hold();
      int n;
      awaddr = 32'h44; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (awready !== 1'b1 && n < 20);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      awaddr = 32'h08; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0) begin
            errors++; $display("FAIL b_hold[%0d]: bvalid=%b bresp=%b awready=%b required 1/10/0", i, bvalid, bresp, awready); end
         @(posedge clk); #1;
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      checks++; if (bvalid !== 1'b0) begin
         errors++; $display("FAIL b_release: bvalid=%b required 0", bvalid); end

      araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (arready !== 1'b1 && n < 20);
      @(posedge clk); #1;
      araddr = 32'h40;
      for (int i = 0; i < 5; i++) begin
         checks++; if (rvalid !== 1'b1 || rdata !== 32'h1 || rresp !== 2'b00 || arready !== 1'b0) begin
            errors++; $display("FAIL r_hold[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b required 1/00000001/00/0", i, rvalid, rdata, rresp, arready); end
         @(posedge clk); #1;
      end
      arvalid = 1'b0; rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      checks++; if (rvalid !== 1'b0) begin
         errors++; $display("FAIL r_release: rvalid=%b required 0", rvalid); end
   endtask

   task automatic test_reset_mid();
      logic [1:0]  resp;
      logic [31:0] data;
      int n;
      awaddr = 32'h1C; wdata = 32'hdeadbeef; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (awready !== 1'b1 && n < 20);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         errors++; $display("FAIL pre_reset_resp: bvalid=%b bresp=%b required 1/00", bvalid, bresp); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++; if ({awready, wready, bvalid, arready, rvalid, aes_start, bresp, rresp} !== 10'b0 || rdata !== 32'h0) begin
         errors++; $display("FAIL mid_reset_outputs: got %b rdata=%h required all 0", {awready, wready, bvalid, arready, rvalid, aes_start, bresp, rresp}, rdata); end
      checks++; if (aes_key !== 192'h0 || aes_pt !== 128'h0) begin
         errors++; $display("FAIL mid_reset_regs: key=%h pt=%h required 0", aes_key, aes_pt); end
      bready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bready = 1'b0;
      checks++; if (bvalid !== 1'b0) begin
         errors++; $display("FAIL mid_reset_no_resp: bvalid=%b required 0", bvalid); end
      axi_write(32'h18, 32'h12345678, 4'hF, 1'b0, resp);
      checks++; if (resp !== 2'b00 || aes_key !== {160'h0, 32'h12345678}) begin
         errors++; $display("FAIL key_rewrite: resp=%b key=%h required 00 and ...12345678", resp, aes_key); end
      axi_read(32'h18, data, resp);
`ifdef AES_KEY_READBACK_EN
      checks++; if (data !== 32'h12345678 || resp !== 2'b00) begin
         errors++; $display("FAIL key_readback: got %h/%b required 12345678/00", data, resp); end
`else
      checks++; if (data !== 32'h0 || resp !== 2'b10) begin
         errors++; $display("FAIL key_readback: got %h/%b required 00000000/10", data, resp); end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      aes_ct = '0; aes_ct_valid = 1'b0;
      test_reset();
      test_key_write();
      test_pt_start();
      test_busy();
      test_done();
      test_strobe_and_errors();
      test_start_ct_same_edge();
      test_back_to_back_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_axi4lite_responder.md
AES_AXI4LITE_RESPONDER -- requirements
Module: aes_axi4lite_responder

Interface
REQ-001 Parameter AW, default 32: AXI4-lite address width.
REQ-002 Parameter DW, default 32: AXI4-lite data width; only 32 supported.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 awaddr_i/awvalid_i in AW/1, awready_o out 1  write-address channel.
REQ-006 wdata_i/wstrb_i/wvalid_i in DW/DW/8/1, wready_o out 1  write-data channel.
REQ-007 bresp_o/bvalid_o out 2/1, bready_i in 1  write-response channel.
REQ-008 araddr_i/arvalid_i in AW/1, arready_o out 1  read-address channel.
REQ-009 rdata_o/rresp_o/rvalid_o out DW/2/1, rready_i in 1  read-data channel.
REQ-010 aes_start_o  out  1  one-cycle start pulse to the AES core.
REQ-011 aes_key_o  out  192  key; aes_pt_o  out  128  plaintext.
REQ-012 aes_ct_i  in  128  ciphertext; aes_ct_valid_i  in  1  core-done pulse.

Function
REQ-013 Map (byte offsets, addr[5:2] decoded, addr[1:0] ignored): 0x00 START (W), 0x04 DONE (R, bit0), 0x08-0x14 PT, 0x18-0x2C KEY, 0x30-0x3C CT (R); all other offsets unmapped.
REQ-014 PT/KEY word order: highest-address word is most significant (KEY 0x2C = key[191:160], PT 0x14 = pt[127:96]).
REQ-015 CT word order: lowest-address word is most significant (CT 0x30 = ct[127:96]).
REQ-016 Write FSM: W_IDLE -> W_ACCEPT once awvalid_i and wvalid_i both high -> W_RESP -> W_IDLE on bvalid_o & bready_i.
REQ-017 awready_o and wready_o are high together, for exactly one cycle, only in W_ACCEPT; the register update occurs on that edge.
REQ-018 bvalid_o is high throughout W_RESP; bresp_o is held stable until accepted.
REQ-019 Read FSM (independent of write FSM): R_IDLE -> R_ACCEPT on arvalid_i -> R_DATA -> R_IDLE on rvalid_o & rready_i.
REQ-020 arready_o is high for one cycle in R_ACCEPT; rdata_o is captured on that edge and held stable through R_DATA.
REQ-021 A write of bit0 = 1 to START drives aes_start_o high for exactly the next cycle, clears DONE, and sets busy; bit0 = 0 has no effect and returns OKAY.
REQ-022 On aes_ct_valid_i, CT is latched from aes_ct_i, DONE is set sticky, and busy is cleared.
REQ-023 Writes to PT/KEY/START while busy are discarded and return SLVERR (2'b10).
REQ-024 Unmapped writes, writes to DONE/CT, and unmapped reads return SLVERR; unmapped reads return rdata 0.
REQ-025 Byte strobes are honoured on PT/KEY writes; START acts only if wstrb_i[0] is set.
REQ-026 When a read capture and a register update occur on the same edge, the read returns the pre-update value.
REQ-027 aes_ct_valid_i on the same edge as a START write: the START write wins (DONE ends cleared, busy ends set), and the incoming CT is still latched.
REQ-028 aes_ct_valid_i while not busy: CT is latched and DONE is set.

Reset
REQ-029 While rst_ni = 0 at a clock edge: both FSMs go to IDLE, all ready/valid outputs are 0, bresp_o/rresp_o/rdata_o are 0, aes_start_o is 0, and PT/KEY/CT/DONE/busy are cleared.
REQ-030 Reset mid-transaction abandons the transaction without emitting a response; the master is required to reissue it.

Configuration
REQ-031 Macro AES_KEY_READBACK_EN.
- Defined: KEY offsets are readable with OKAY, returning stored words.
- Undefined: KEY reads return rdata 0 with SLVERR; key writes are unaffected.

Verification
REQ-032 Write KEY 0x2C..0x18 = 2b7e1516,28aed2a6,abf71588,09cf4f3c,2b7e1516,28aed2a6 -> aes_key_o = 2b7e151628aed2a6abf7158809cf4f3c2b7e151628aed2a6, each bresp OKAY.
REQ-033 Write PT 0x14..0x08 = 3243f6a8,885a308d,313198a2,e0370734, then START = 1 -> aes_start_o pulses one cycle with aes_pt_o = 3243f6a8885a308d313198a2e0370734; DONE reads 0.
REQ-034 Stub core asserts aes_ct_valid_i 10 cycles later with ct = 4fcb8db85784a2c1bb77db7ede3217ac -> DONE reads 1; CT 0x30..0x3C read 4fcb8db8,5784a2c1,bb77db7e,de3217ac.
REQ-035 PT write while busy, and read of 0x40 -> SLVERR in both cases; PT unchanged; rdata 0.
REQ-036 bready_i/rready_i held low 5 cycles -> bvalid_o/rvalid_o stay high with stable bresp/rdata; no new AW/AR is accepted in that time.
REQ-037 rst_ni low for 1 cycle during W_RESP, and KEY read with and without AES_KEY_READBACK_EN -> all outputs 0 after reset; key word returned (OKAY) vs 0 (SLVERR).
